reg_file: RTL and testbench



---
 rtl/reg_file.sv | 40 ++++
 tb/tb_reg_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: DEPTH x DATA_WIDTH storage, one synchronous write port, one combinational read port.
// Writes land on the rising edge, reads have zero latency, and there is no backpressure (full-rate writes).
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeenable,
  input  logic [ADDR_WIDTH-1:0] wadd,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] radd,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // An X/Z strobe falls through to the hold path, so it never writes.
  always_comb begin
    mem_d = mem_q;
    if (writeenable) begin
      mem_d[wadd] = wdata;
    end
  end

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // No bypass: a same-address write is visible only after its edge.
  assign rdata = mem_q[radd];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: vector table plus hand sequences, with a read-data scoreboard queue.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       writeenable;
  logic [3:0] wadd;
  logic [7:0] wdata;
  logic [3:0] radd;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  reg_file #(
    .DATA_WIDTH(8),
    .DEPTH     (16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .writeenable(writeenable),
    .wadd       (wadd),
    .wdata      (wdata),
    .radd       (radd),
    .rdata      (rdata)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    logic       r;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    logic [7:0] pre;
    logic [7:0] post;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_rd();
    sb_t e;
    #1;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: rdata=%h, no expected value queued", rdata);
    end else begin
      e = sb_q.pop_front();
      if (rdata !== e.exp) begin
        n_bad++;
        $display("FAIL %s: radd=%h rdata=%h expected=%h", e.name, radd, rdata, e.exp);
      end
    end
  endtask

  task automatic read_at(input string name, input logic [3:0] a, input logic [7:0] exp);
    radd = a;
    expect_rd(name, exp);
    check_rd();
  endtask

  initial begin
    // rst, we, wadd, wdata, radd, rdata before edge, rdata after edge
    tbl[0]  = '{"wr_0_12",       1'b1, 1'b1, 4'h0, 8'h12, 4'h0, 8'h00, 8'h12};
    tbl[1]  = '{"wr_3_10",       1'b1, 1'b1, 4'h3, 8'h10, 4'h3, 8'h00, 8'h10};
    tbl[2]  = '{"wr_A_rd_0",     1'b1, 1'b1, 4'hA, 8'h17, 4'h0, 8'h12, 8'h12};
    tbl[3]  = '{"wr_B_20",       1'b1, 1'b1, 4'hB, 8'h20, 4'hB, 8'h00, 8'h20};
    tbl[4]  = '{"wr_8_rd_A",     1'b1, 1'b1, 4'h8, 8'h3D, 4'hA, 8'h17, 8'h17};
    tbl[5]  = '{"rd_8",          1'b1, 1'b0, 4'h4, 8'hAA, 4'h8, 8'h3D, 8'h3D};
    tbl[6]  = '{"rd_3",          1'b1, 1'b0, 4'h4, 8'hAA, 4'h3, 8'h10, 8'h10};
    tbl[7]  = '{"rd_5_unwritten",1'b1, 1'b0, 4'h4, 8'hAA, 4'h5, 8'h00, 8'h00};
    tbl[8]  = '{"we_low_4",      1'b1, 1'b0, 4'h4, 8'hAA, 4'h4, 8'h00, 8'h00};
    tbl[9]  = '{"we_low_4_again",1'b1, 1'b0, 4'h4, 8'hAA, 4'h4, 8'h00, 8'h00};
    tbl[10] = '{"we_high_4",     1'b1, 1'b1, 4'h4, 8'hAA, 4'h4, 8'h00, 8'hAA};
    tbl[11] = '{"wr_7_11",       1'b1, 1'b1, 4'h7, 8'h11, 4'h7, 8'h00, 8'h11};
    tbl[12] = '{"same_addr_7",   1'b1, 1'b1, 4'h7, 8'h55, 4'h7, 8'h11, 8'h55};
    tbl[13] = '{"last_wr_wins_7",1'b1, 1'b1, 4'h7, 8'h66, 4'h7, 8'h55, 8'h66};
    tbl[14] = '{"rst_over_wr_2", 1'b0, 1'b1, 4'h2, 8'h99, 4'h2, 8'h00, 8'h00};
    tbl[15] = '{"post_rst_7",    1'b1, 1'b0, 4'h2, 8'h99, 4'h7, 8'h00, 8'h00};
    tbl[16] = '{"post_rst_A",    1'b1, 1'b0, 4'h2, 8'h99, 4'hA, 8'h00, 8'h00};
    tbl[17] = '{"wr_2_after_rst",1'b1, 1'b1, 4'h2, 8'h99, 4'h2, 8'h00, 8'h99};

    rst         = 1'b0;
    writeenable = 1'b0;
    wadd        = '0;
    wdata       = '0;
    radd        = '0;
    tick();

    // Fill with FF, confirm, then one reset edge must clear everything.
    rst         = 1'b1;
    writeenable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wadd  = 4'(i);
      wdata = 8'hFF;
      tick();
    end
    writeenable = 1'b0;
    for (int i = 0; i < 16; i++) read_at("fill_ff", 4'(i), 8'hFF);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) read_at("reset_clear", 4'(i), 8'h00);
    tick();

    for (int k = 0; k < 18; k++) begin
      rst         = tbl[k].r;
      writeenable = tbl[k].we;
      wadd        = tbl[k].wa;
      wdata       = tbl[k].wd;
      radd        = tbl[k].ra;
      expect_rd({tbl[k].name, "_pre"}, tbl[k].pre);
      check_rd();
      expect_rd({tbl[k].name, "_post"}, tbl[k].post);
      tick();
      check_rd();
    end
    writeenable = 1'b0;
    rst         = 1'b1;

    // Mid-cycle changes on write inputs with the strobe low must not store.
    tick();
    wadd  = 4'h9;
    wdata = 8'h5A;
    #2;
    wdata = 8'hA5;
    tick();
    read_at("no_wr_9", 4'h9, 8'h00);
    tick();

    // Full walk: distinct pattern per address exposes any address aliasing.
    writeenable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a     = 4'(i);
      wadd  = a;
      wdata = {a, ~a};
      tick();
    end
    writeenable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      read_at("walk", a, {a, ~a});
    end
    read_at("walk_last_F", 4'hF, 8'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
